// File: rtl/elm_layer_streamer.sv
// Captures a whole ELM layer in one cycle and replays it as a one-element-per-cycle stream.
// Optional running argmax of each completed stream is enabled by defining ELM_STREAM_ARGMAX_EN.
module elm_layer_streamer #(
    parameter int NUM_NEURONS = 40,
    parameter int IN_WIDTH    = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [NUM_NEURONS*IN_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [IDX_WIDTH-1:0]          out_index,
    output logic                          busy,
    output logic                          overrun
`ifdef ELM_STREAM_ARGMAX_EN
    ,
    output logic                          argmax_valid,
    output logic [IDX_WIDTH-1:0]          argmax_index,
    output logic [IN_WIDTH-1:0]           argmax_value
`endif
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    state_e state_q, state_d;

    logic [IN_WIDTH-1:0]   cap_q [NUM_NEURONS];
    logic [IN_WIDTH-1:0]   cap_d [NUM_NEURONS];
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [IDX_WIDTH-1:0]  out_index_q, out_index_d;
    logic                  overrun_q, overrun_d;

    logic                  capture;
    logic [IDX_WIDTH-1:0]  next_idx;

    // A capture is accepted when idle or on the final element, giving gapless back-to-back streams.
    assign capture  = in_valid && ((state_q == IDLE) || out_last_q);
    assign next_idx = out_index_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_last_q && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cap_d       = cap_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_index_d = out_index_q;
        overrun_d   = overrun_q;

        if (capture) begin
            for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
                cap_d[k] = in_data[k*IN_WIDTH +: IN_WIDTH];
            end
            out_data_d  = DATA_WIDTH'(in_data[IN_WIDTH-1:0]);
            out_valid_d = 1'b1;
            out_index_d = '0;
        end else if ((state_q == STREAM) && !out_last_q) begin
            out_data_d  = DATA_WIDTH'(cap_q[next_idx]);
            out_valid_d = 1'b1;
            out_index_d = next_idx;
            out_last_d  = (next_idx == LAST_IDX);
        end

        if (in_valid && (state_q == STREAM) && !out_last_q) begin
            overrun_d = 1'b1;
        end
    end

    // Capture buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        cap_q <= cap_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_index_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_index_q <= out_index_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_index = out_index_q;
    assign busy      = out_valid_q;
    assign overrun   = overrun_q;

`ifdef ELM_STREAM_ARGMAX_EN
    logic [IN_WIDTH-1:0]  run_val_q, run_val_d;
    logic [IDX_WIDTH-1:0] run_idx_q, run_idx_d;
    logic                 am_valid_q, am_valid_d;
    logic [IDX_WIDTH-1:0] am_idx_q, am_idx_d;
    logic [IN_WIDTH-1:0]  am_val_q, am_val_d;
    logic [IN_WIDTH-1:0]  cur_elem;
    logic [IN_WIDTH-1:0]  cand_val;
    logic [IDX_WIDTH-1:0] cand_idx;

    assign cur_elem = out_data_q[IN_WIDTH-1:0];

    // Tracks the element currently on the output; element 0 restarts the running maximum.
    always_comb begin
        run_val_d  = run_val_q;
        run_idx_d  = run_idx_q;
        am_valid_d = 1'b0;
        am_idx_d   = am_idx_q;
        am_val_d   = am_val_q;
        cand_val   = run_val_q;
        cand_idx   = run_idx_q;

        if ((out_index_q == '0) || (cur_elem > run_val_q)) begin
            cand_val = cur_elem;
            cand_idx = out_index_q;
        end

        if (out_valid_q) begin
            run_val_d = cand_val;
            run_idx_d = cand_idx;
            if (out_last_q) begin
                am_valid_d = 1'b1;
                am_idx_d   = cand_idx;
                am_val_d   = cand_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_val_q  <= '0;
            run_idx_q  <= '0;
            am_valid_q <= 1'b0;
            am_idx_q   <= '0;
            am_val_q   <= '0;
        end else begin
            run_val_q  <= run_val_d;
            run_idx_q  <= run_idx_d;
            am_valid_q <= am_valid_d;
            am_idx_q   <= am_idx_d;
            am_val_q   <= am_val_d;
        end
    end

    assign argmax_valid = am_valid_q;
    assign argmax_index = am_idx_q;
    assign argmax_value = am_val_q;
`endif

endmodule

// File: doc/elm_layer_streamer.md
Name: elm_layer_streamer

Overview:
- Sits between two ELM layers, or between the hidden layer and the output stage.
- Captures the activation outputs of all NUM_NEURONS neurons in a layer. All neurons assert their out-valid together, and the block captures the whole layer in that one cycle.
- Re-serialises the captured values into a one-element-per-cycle stream. This stream drives the myinput/myinputValid ports of every neuron in the next layer.
- This block is the transmitter side of the neuron input interface.

Parameters:
- NUM_NEURONS, 40, neurons in the source layer, which is also the stream length. Must be >= 2.
- IN_WIDTH, 16, width of each neuron activation output (ROM output width).
- DATA_WIDTH, 16, width of the next layer's myinput. Must be >= IN_WIDTH.
- IDX_WIDTH, $clog2(NUM_NEURONS), index width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, single-cycle pulse from the source layer's outvalid.
- in_data, in, NUM_NEURONS*IN_WIDTH, flattened activations; neuron k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- out_data, out, DATA_WIDTH, stream element that drives the next layer's myinput.
- out_valid, out, 1, drives the next layer's myinputValid.
- out_last, out, 1, high with element NUM_NEURONS-1.
- out_index, out, IDX_WIDTH, index of the current element.
- busy, out, 1, high while streaming.
- overrun, out, 1, sticky flag: a capture was dropped.

Behaviour:
- Reset (asynchronous, active-high): every output is 0 and the state is IDLE. The capture buffer contents are don't-care.
- States:
  - IDLE: on in_valid, capture all of in_data into the buffer, set idx=0, go to STREAM.
  - STREAM: each cycle, present buffer[idx] and increment idx. When idx==NUM_NEURONS-1, go to IDLE, unless a capture is accepted in that cycle (see back-to-back).
- Outputs are registered:
  - If in_valid is sampled at edge T, element 0 appears in the cycle after T. Element k appears k cycles later.
  - out_valid is high for exactly NUM_NEURONS consecutive cycles.
  - busy equals out_valid.
- Width rule: out_data = {(DATA_WIDTH-IN_WIDTH) zeros, element}. The activation is unsigned and is zero-extended, never sign-extended.
- out_index equals the element number. out_last is high only with index NUM_NEURONS-1.
- Back-to-back capture:
  - in_valid sampled while out_last is high (the final element cycle) is accepted.
  - The buffer reloads and the stream restarts at index 0 on the next cycle, with no gap in out_valid.
- Overrun:
  - in_valid sampled during STREAM while out_last is low is dropped.
  - The stream in progress continues unchanged, and overrun is set to 1.
  - Only reset clears overrun.
- Reset asserted mid-stream clears out_valid, out_last and busy immediately (asynchronously). No partial stream resumes after reset.
- The block produces no idle-cycle glitches: out_data holds its last value when out_valid is 0.

Optional Feature:
- Macro: ELM_STREAM_ARGMAX_EN.
- When defined, three extra outputs are added:
  - argmax_valid (1): single-cycle pulse, one cycle after out_last.
  - argmax_index (IDX_WIDTH): index of the largest element of the completed stream.
  - argmax_value (IN_WIDTH): value of that element.
- Argmax rules:
  - Comparison is unsigned and strictly greater, so ties keep the lowest index.
  - The running maximum re-initialises from element 0 of each stream.
  - Results hold until the next argmax_valid.
  - On reset, all three outputs are 0.
  - On a back-to-back capture, argmax_valid still pulses for the finished stream.
- When not defined: these ports and their logic do not exist, and all other behaviour is identical.

Test Plan:
- Basic stream: NUM_NEURONS=40, in_data neuron k = k+1, one in_valid pulse. Expect out_valid for 40 cycles starting the next cycle, out_data = 1..40, out_index = 0..39, out_last only at index 39, busy falls after that cycle.
- Zero-extension: IN_WIDTH=8, DATA_WIDTH=16, neuron 0 = 8'hFF. Expect out_data = 16'h00FF.
- Overrun: second in_valid at element index 10. Expect the stream to continue with the original data, 40 elements total, overrun=1 and staying 1 until rst.
- Back-to-back: second in_valid (neuron k = 100+k) in the out_last cycle. Expect 80 contiguous out_valid cycles, the second run reading 100..139, and overrun still 0.
- Reset mid-stream: assert rst asynchronously (between clock edges) at index 20. Expect out_valid, busy and out_last to be 0 immediately. After release, a fresh in_valid streams from index 0.
- ELM_STREAM_ARGMAX_EN defined: values with a maximum of 200 at indices 7 and 30. Expect argmax_index=7, argmax_value=200, and argmax_valid pulsing one cycle after out_last.
